// File: rtl/pdm_mic_ctrl.sv
// -----------------------------------------------------------------------------
// pdm_mic_ctrl
//
// Control and framing logic for a stereo PDM microphone front end.
//
// The block generates the microphone bit clock and the strobes that drive two
// external CIC decimators, one per channel. Left data is taken just before the
// rising edge of pdm_clk and right data just before the falling edge. Every
// DECIM PDM periods a decimation strobe (en_pcm) is issued. One cycle later the
// CIC outputs are captured. The first WARMUP captures after each start are
// thrown away while the CIC filters settle. Later captures go into a 4-entry
// stereo FIFO, which is drained through a valid/ready handshake.
//
// Ports
//   clk            system clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   start / stop   one-cycle capture requests
//   pdm_clk        microphone bit clock (low for phase < HALF)
//   en_left        left integrator strobe  (phase == HALF-1)
//   en_right       right integrator strobe (phase == 2*HALF-1)
//   en_pcm         comb-stage decimation strobe
//   cic_reset      reset to both CIC instances (held in IDLE and FLUSH)
//   pcm_left_in    left CIC output, W bits
//   pcm_right_in   right CIC output, W bits
//   out_valid      FIFO non-empty
//   out_ready      downstream accept
//   out_left/right FIFO head sample pair (0 when the FIFO is empty)
//   overflow       sticky flag; a RUN capture was dropped on a full FIFO
//   busy           state is not IDLE
// -----------------------------------------------------------------------------
module pdm_mic_ctrl #(
  parameter int W      = 16,
  parameter int HALF   = 10,
  parameter int DECIM  = 32,
  parameter int WARMUP = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         stop,
  output logic         pdm_clk,
  output logic         en_left,
  output logic         en_right,
  output logic         en_pcm,
  output logic         cic_reset,
  input  logic [W-1:0] pcm_left_in,
  input  logic [W-1:0] pcm_right_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_left,
  output logic [W-1:0] out_right,
  output logic         overflow,
  output logic         busy
);

  localparam int PH_W  = $clog2(2 * HALF);
  localparam int PER_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int FR_W  = $clog2(WARMUP + 2);

  localparam logic [PH_W-1:0]  PH_LEFT  = PH_W'(HALF - 1);
  localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(HALF);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * HALF - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(DECIM - 1);
  localparam logic [FR_W-1:0]  FR_DONE  = FR_W'(WARMUP);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_WARMUP = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  // Control state
  state_t            state_q,     state_d;
  logic [PH_W-1:0]   phase_q,     phase_d;
  logic [PER_W-1:0]  period_q,    period_d;
  logic [FR_W-1:0]   frame_q,     frame_d;
  logic              pdm_clk_q,   pdm_clk_d;
  logic              en_left_q,   en_left_d;
  logic              en_right_q,  en_right_d;
  logic              en_pcm_q,    en_pcm_d;
  logic              cap_q,       cap_d;
  logic              cic_reset_q, cic_reset_d;
  logic              busy_q,      busy_d;
  logic              overflow_q,  overflow_d;

  // FIFO control
  logic [1:0]        wr_ptr_q,    wr_ptr_d;
  logic [1:0]        rd_ptr_q,    rd_ptr_d;
  logic [2:0]        count_q,     count_d;
  logic              push;
  logic              pop;
  logic              act_d;

  // FIFO storage (data only, never reset)
  logic [W-1:0]      mem_left_q  [4];
  logic [W-1:0]      mem_right_q [4];

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    period_d   = period_q;
    frame_d    = frame_q;
    overflow_d = overflow_q;
    en_pcm_d   = 1'b0;
    cap_d      = 1'b0;
    push       = 1'b0;
    pop        = (count_q != 3'd0) && out_ready;

    case (state_q)
      S_IDLE: begin
        // A start that coincides with a stop is ignored.
        if (start && !stop) begin
          state_d    = S_FLUSH;
          overflow_d = 1'b0;
        end
      end

      S_FLUSH: begin
        phase_d  = '0;
        period_d = '0;
        frame_d  = '0;
        if (stop) begin
          state_d = S_IDLE;
        end else begin
          state_d = (WARMUP == 0) ? S_RUN : S_WARMUP;
        end
      end

      S_WARMUP, S_RUN: begin
        if (stop) begin
          // Stopping zeroes the counters and drops any pending strobe or
          // capture, so IDLE always starts from a clean slate.
          state_d  = S_IDLE;
          phase_d  = '0;
          period_d = '0;
          frame_d  = '0;
        end else begin
          if (phase_q == PH_LAST) begin
            phase_d  = '0;
            period_d = (period_q == PER_LAST) ? '0 : period_q + PER_W'(1);
          end else begin
            phase_d  = phase_q + PH_W'(1);
          end

          // en_right_q marks the last phase of the period held in period_q,
          // so the decimation strobe lands in the cycle right after it.
          en_pcm_d = en_right_q && (period_q == PER_LAST);
          cap_d    = en_pcm_q;

          if (cap_q) begin
            if (state_q == S_WARMUP) begin
              frame_d = frame_q + FR_W'(1);
              if (frame_d == FR_DONE) begin
                state_d = S_RUN;
              end
            end else if ((count_q != 3'd4) || pop) begin
              // A pop in the same cycle frees a slot for this capture.
              push = 1'b1;
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The PDM outputs are registered from the next-state values, so they
    // line up exactly with the phase counter they describe.
    act_d       = (state_d == S_WARMUP) || (state_d == S_RUN);
    pdm_clk_d   = act_d && (phase_d >= PH_HIGH);
    en_left_d   = act_d && (phase_d == PH_LEFT);
    en_right_d  = act_d && (phase_d == PH_LAST);
    cic_reset_d = (state_d == S_IDLE) || (state_d == S_FLUSH);
    busy_d      = (state_d != S_IDLE);

    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    count_d  = count_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      phase_q     <= '0;
      period_q    <= '0;
      frame_q     <= '0;
      pdm_clk_q   <= 1'b0;
      en_left_q   <= 1'b0;
      en_right_q  <= 1'b0;
      en_pcm_q    <= 1'b0;
      cap_q       <= 1'b0;
      cic_reset_q <= 1'b1;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      period_q    <= period_d;
      frame_q     <= frame_d;
      pdm_clk_q   <= pdm_clk_d;
      en_left_q   <= en_left_d;
      en_right_q  <= en_right_d;
      en_pcm_q    <= en_pcm_d;
      cap_q       <= cap_d;
      cic_reset_q <= cic_reset_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_left_q[wr_ptr_q]  <= pcm_left_in;
      mem_right_q[wr_ptr_q] <= pcm_right_in;
    end
  end

  assign pdm_clk   = pdm_clk_q;
  assign en_left   = en_left_q;
  assign en_right  = en_right_q;
  assign en_pcm    = en_pcm_q;
  assign cic_reset = cic_reset_q;
  assign busy      = busy_q;
  assign overflow  = overflow_q;
  assign out_valid = (count_q != 3'd0);
  // The head is masked while the FIFO is empty, so stale storage never shows.
  assign out_left  = out_valid ? mem_left_q[rd_ptr_q]  : '0;
  assign out_right = out_valid ? mem_right_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
module tb_pdm_mic_ctrl;

  localparam int W = 16;
  // The first RUN capture comes 1923 cycles after start; later ones come
  // every 640 cycles (2*HALF*DECIM).
  localparam int CAP0  = 1923;
  localparam int FRAME = 640;

  logic         clk = 1'b0;
  logic         reset, start, stop, out_ready;
  logic [W-1:0] pcm_l, pcm_r;
  logic         pdm_clk, en_left, en_right, en_pcm, cic_reset;
  logic         out_valid, overflow, busy;
  logic [W-1:0] out_left, out_right;

  pdm_mic_ctrl #(.W(W), .HALF(10), .DECIM(32), .WARMUP(2)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .pdm_clk(pdm_clk), .en_left(en_left), .en_right(en_right),
    .en_pcm(en_pcm), .cic_reset(cic_reset),
    .pcm_left_in(pcm_l), .pcm_right_in(pcm_r),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_left(out_left), .out_right(out_right),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int delivered = 0;
  int base;
  int f_l, f_r, f_p, f_v;
  int strobes;
  bit use_tbl;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;
  logic [W-1:0] tbl_l [8];
  logic [W-1:0] tbl_r [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: compares every accepted FIFO head with the queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL pop_unexpected: got %0h expected none", {out_left, out_right});
      end else begin
        mon_e = exp_q.pop_front();
        check("pop_data", {out_left, out_right}, mon_e);
        delivered++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_cap();
    f_l = -1; f_r = -1; f_p = -1; f_v = -1;
    start = 1'b1;
    cyc = 0;
    tick();
    start = 1'b0;
  endtask

  // Advance to cycle t. At each RUN capture cycle j the inputs are set
  // (table mode) and the pair is pushed as expected when j < npush.
  task automatic run_until(input int t, input int npush);
    int j;
    while (cyc < t) begin
      tick();
      if (cyc >= CAP0 && ((cyc - CAP0) % FRAME) == 0) begin
        j = (cyc - CAP0) / FRAME;
        if (use_tbl) begin
          pcm_l = tbl_l[j % 8];
          pcm_r = tbl_r[j % 8];
        end
        if (j < npush) exp_q.push_back({pcm_l, pcm_r});
      end
      if (en_left   && f_l < 0) f_l = cyc;
      if (en_right  && f_r < 0) f_r = cyc;
      if (en_pcm    && f_p < 0) f_p = cyc;
      if (out_valid && f_v < 0) f_v = cyc;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pdm_clk"},   pdm_clk,   1'b0);
    check({tag, "_en_left"},   en_left,   1'b0);
    check({tag, "_en_right"},  en_right,  1'b0);
    check({tag, "_en_pcm"},    en_pcm,    1'b0);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_overflow"},  overflow,  1'b0);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_cic_reset"}, cic_reset, 1'b1);
    check({tag, "_out_left"},  out_left,  16'h0000);
    check({tag, "_out_right"}, out_right, 16'h0000);
  endtask

  initial begin
    tbl_l = '{16'h0A01, 16'h0A02, 16'h0A03, 16'h0A04, 16'h0A05, 16'h0A06, 16'h0A07, 16'h0A08};
    tbl_r = '{16'hB101, 16'hB102, 16'hB103, 16'hB104, 16'hB105, 16'hB106, 16'hB107, 16'hB108};
    reset = 1'b1; start = 1'b0; stop = 1'b0; out_ready = 1'b1;
    pcm_l = 16'h1234; pcm_r = 16'hFEDC; use_tbl = 1'b0;
    repeat (3) tick();
    check_reset_vals("por");
    reset = 1'b0;
    tick();

    // Timing and held data
    start_cap();
    check("flush_cic_reset", cic_reset, 1'b1);
    check("flush_busy", busy, 1'b1);
    check("flush_pdm_clk", pdm_clk, 1'b0);
    base = delivered;
    run_until(CAP0 + 2 * FRAME + 10, 99);
    check("first_en_left", f_l, 11);
    check("first_en_right", f_r, 21);
    check("first_en_pcm", f_p, 642);
    check("first_out_valid", f_v, 1924);
    check("data_delivered", delivered - base, 3);
    check("data_no_overflow", overflow, 1'b0);
    check("data_queue_empty", exp_q.size(), 0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stop_busy", busy, 1'b0);

    // Overflow with 6 RUN frames and no reader
    use_tbl = 1'b1; pcm_l = 16'hDEAD; pcm_r = 16'hBEEF;
    out_ready = 1'b0;
    base = delivered;
    start_cap();
    run_until(CAP0 + 3 * FRAME + 1, 4);
    check("ovf_after4", overflow, 1'b0);
    check("ovf_valid4", out_valid, 1'b1);
    run_until(CAP0 + 4 * FRAME + 1, 4);
    check("ovf_after5", overflow, 1'b1);
    run_until(CAP0 + 5 * FRAME + 1, 4);
    check("ovf_after6", overflow, 1'b1);
    check("ovf_head_is_first", {out_left, out_right}, {tbl_l[0], tbl_r[0]});
    out_ready = 1'b1;
    run_until(CAP0 + 5 * FRAME + 12, 4);
    check("ovf_drain_count", delivered - base, 4);
    check("ovf_drained_valid", out_valid, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    check("ovf_sticky_after_stop", overflow, 1'b1);

    // Full FIFO with a pop in the same cycle as a capture
    out_ready = 1'b0;
    pcm_l = 16'hDEAD; pcm_r = 16'hBEEF;
    base = delivered;
    start_cap();
    check("start_clears_overflow", overflow, 1'b0);
    run_until(CAP0 + 4 * FRAME - 1, 5);
    run_until(CAP0 + 4 * FRAME, 5);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("simul_overflow", overflow, 1'b0);
    check("simul_popped_one", delivered - base, 1);
    check("simul_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    run_until(cyc + 10, 5);
    check("simul_drain_count", delivered - base, 5);
    check("simul_drained_valid", out_valid, 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;

    // Stop in RUN at phase 5
    out_ready = 1'b0;
    pcm_l = 16'hDEAD; pcm_r = 16'hBEEF;
    base = delivered;
    start_cap();
    run_until(1947, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    check("stopr_busy", busy, 1'b0);
    check("stopr_pdm_clk", pdm_clk, 1'b0);
    strobes = 0;
    repeat (700) begin
      tick();
      if (en_left || en_right || en_pcm || pdm_clk || busy) strobes++;
    end
    check("stopr_no_strobes", strobes, 0);
    check("stopr_fifo_kept", out_valid, 1'b1);
    out_ready = 1'b1;
    repeat (4) tick();
    check("stopr_drain_count", delivered - base, 1);
    check("stopr_drained_valid", out_valid, 1'b0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check("startstop_busy", busy, 1'b0);
    repeat (3) tick();
    check("startstop_still_idle", busy, 1'b0);
    check("startstop_pdm_clk", pdm_clk, 1'b0);

    // Reset mid-WARMUP, then a fresh start
    use_tbl = 1'b0; pcm_l = 16'h5A5A; pcm_r = 16'hA5A5;
    out_ready = 1'b1;
    start_cap();
    run_until(700, 0);
    check("warm_busy", busy, 1'b1);
    reset = 1'b1; start = 1'b1;
    tick();
    reset = 1'b0; start = 1'b0;
    check_reset_vals("midrst");
    tick();
    base = delivered;
    start_cap();
    run_until(CAP0 + 10, 1);
    check("rst_first_en_left", f_l, 11);
    check("rst_first_en_pcm", f_p, 642);
    check("rst_first_out_valid", f_v, 1924);
    check("rst_delivered", delivered - base, 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
